mem_stage_lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 26 ++
 rtl/mem_stage_lsu_data_mem_be.sv | 30 +++
 rtl/mem_stage_lsu.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: access-size codes,
// FSM states and the bubble instruction.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {S_IDLE, S_WAIT} lsu_state_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    // Unknown funct3 codes fall through to word accesses.
    function automatic lsu_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_data_mem_be.sv
// Byte-enabled data memory: synchronous lane writes, combinational word read.
// Contents are deliberately not reset.
module data_mem_be #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// RISC-V MEM stage: branch resolve, sized loads/stores with alignment checks,
// wait-state FSM with stall handshake, and the MEM/WB register.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            BranchM,
    input  logic            RegWriteM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic            memtoRegM,
    input  logic [2:0]      funct3M,
    input  logic            ZeroM,
    input  logic [31:0]     InstrM,
    input  logic [XLEN-1:0] ALUOutM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [XLEN-1:0] PCTargetM,
    output logic            PCSrcM,
    output logic [XLEN-1:0] PCTargetOut,
    output logic            StallM,
    output logic            MisalignM,
    output logic            RegWriteW,
    output logic            memtoRegW,
    output logic [XLEN-1:0] ALUOutW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [31:0]     InstrW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT);

    lsu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            reg_write_w_q, reg_write_w_d;
    logic            mem_to_reg_w_q, mem_to_reg_w_d;
    logic [XLEN-1:0] alu_out_w_q, alu_out_w_d;
    logic [XLEN-1:0] read_data_w_q, read_data_w_d;
    logic [31:0]     instr_w_q, instr_w_d;

    logic            access, misalign, aligned_access, stall, done, mem_we;
    lsu_size_e       size;
    logic [1:0]      byte_off;
    logic [3:0]      be;
    logic [XLEN-1:0] st_data, rd_word, ld_data;
    logic [7:0]      lanes [4];
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    assign PCSrcM      = BranchM & ZeroM;
    assign PCTargetOut = PCTargetM;

    assign access   = MemReadM | MemWriteM;
    assign size     = f3_size(funct3M);
    assign byte_off = ALUOutM[1:0];

    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_H:    misalign = ALUOutM[0];
            SZ_W:    misalign = |ALUOutM[1:0];
            default: misalign = 1'b0;
        endcase
        misalign = misalign & access;
    end

    assign MisalignM      = misalign;
    assign aligned_access = access & ~misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (aligned_access && (MEM_LAT > 0)) begin
                    stall   = 1'b1;
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset must drop the stall immediately, not on the next edge.
    assign StallM = stall & ~rst;
    assign done   = aligned_access & ~stall;
    assign mem_we = MemWriteM & done & ~rst;

    always_comb begin
        be      = 4'b1111;
        st_data = WriteDataM;
        case (size)
            SZ_B: begin
                be      = 4'b0001 << byte_off;
                st_data = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
                be      = byte_off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    data_mem_be #(.XLEN(XLEN), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (be),
        .addr  (ALUOutM[AW+1:2]),
        .wdata (st_data),
        .rdata (rd_word)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = rd_word[8*gi +: 8];
    end

    assign ld_byte = lanes[byte_off];
    assign ld_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (funct3M)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            default: ld_data = rd_word;
        endcase
    end

    always_comb begin
        reg_write_w_d  = RegWriteM & ~misalign;
        mem_to_reg_w_d = memtoRegM;
        alu_out_w_d    = ALUOutM;
        read_data_w_d  = (MemReadM & aligned_access) ? ld_data : '0;
        instr_w_d      = InstrM;
        if (stall) begin
            reg_write_w_d  = 1'b0;
            mem_to_reg_w_d = 1'b0;
            alu_out_w_d    = '0;
            read_data_w_d  = '0;
            instr_w_d      = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            alu_out_w_q    <= '0;
            read_data_w_q  <= '0;
            instr_w_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            reg_write_w_q  <= reg_write_w_d;
            mem_to_reg_w_q <= mem_to_reg_w_d;
            alu_out_w_q    <= alu_out_w_d;
            read_data_w_q  <= read_data_w_d;
            instr_w_q      <= instr_w_d;
        end
    end

    assign RegWriteW = reg_write_w_q;
    assign memtoRegW = mem_to_reg_w_q;
    assign ALUOutW   = alu_out_w_q;
    assign ReadDataW = read_data_w_q;
    assign InstrW    = instr_w_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: three instances (MEM_LAT 0/2/3) share stimulus;
// directed vectors, random traffic against a byte-level model, wait/reset sequences.
module tb_mem_stage_lsu;

    localparam int DEPTH = 64;
    localparam int NBYTES = DEPTH * 4;
    localparam int LATS [3] = '{0, 2, 3};
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        BranchM, RegWriteM, MemReadM, MemWriteM, memtoRegM, ZeroM;
    logic [2:0]  funct3M;
    logic [31:0] InstrM, ALUOutM, WriteDataM, PCTargetM;

    logic        pcsrc_o [3];
    logic        stall_o [3];
    logic        misal_o [3];
    logic        rw_o    [3];
    logic        m2r_o   [3];
    logic [31:0] pct_o   [3];
    logic [31:0] alu_o   [3];
    logic [31:0] rd_o    [3];
    logic [31:0] ins_o   [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_stage_lsu #(.XLEN(32), .DEPTH(DEPTH), .MEM_LAT(LATS[gi])) u_dut (
            .clk         (clk),
            .rst         (rst),
            .BranchM     (BranchM),
            .RegWriteM   (RegWriteM),
            .MemReadM    (MemReadM),
            .MemWriteM   (MemWriteM),
            .memtoRegM   (memtoRegM),
            .funct3M     (funct3M),
            .ZeroM       (ZeroM),
            .InstrM      (InstrM),
            .ALUOutM     (ALUOutM),
            .WriteDataM  (WriteDataM),
            .PCTargetM   (PCTargetM),
            .PCSrcM      (pcsrc_o[gi]),
            .PCTargetOut (pct_o[gi]),
            .StallM      (stall_o[gi]),
            .MisalignM   (misal_o[gi]),
            .RegWriteW   (rw_o[gi]),
            .memtoRegW   (m2r_o[gi]),
            .ALUOutW     (alu_o[gi]),
            .ReadDataW   (rd_o[gi]),
            .InstrW      (ins_o[gi])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Byte-addressed reference memory, little-endian.
    logic [7:0] ref_mem [NBYTES];

    function automatic int sz_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit mis_of(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % sz_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
        int sz = sz_of(f3);
        int base = int'(addr % NBYTES);
        logic [31:0] val = '0;
        for (int k = 0; k < sz; k++) val = val | (32'(ref_mem[base + k]) << (8 * k));
        if ((f3 == 3'b000 || f3 == 3'b001) && sz < 4 && val[8*sz-1])
            val = val | (32'hFFFFFFFF << (8 * sz));
        return val;
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int sz = sz_of(f3);
        int base = int'(addr % NBYTES);
        for (int k = 0; k < sz; k++) ref_mem[base + k] = 8'(wd >> (8 * k));
    endtask

    task automatic set_m(input bit re, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit rw, input logic [31:0] instr);
        MemReadM   = re;
        MemWriteM  = we;
        funct3M    = f3;
        ALUOutM    = addr;
        WriteDataM = wd;
        RegWriteM  = rw;
        memtoRegM  = re;
        InstrM     = instr;
    endtask

    // Starts at posedge+1; returns after the completing edge (+1).
    task automatic run_until_done(input int idx, input string tag, output int stalls);
        bit s;
        bit timeout = 1'b1;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            #3;
            s = stall_o[idx];
            @(posedge clk); #1;
            if (s) begin
                stalls++;
                chk({tag, " bubble RegWriteW"}, 32'(rw_o[idx]), 32'd0);
                chk({tag, " bubble memtoRegW"}, 32'(m2r_o[idx]), 32'd0);
                chk({tag, " bubble InstrW"}, ins_o[idx], NOP);
            end else begin
                timeout = 1'b0;
                break;
            end
        end
        chk({tag, " completion timeout"}, 32'(timeout), 32'd0);
        $display("txn %s: lat=%0d stalls=%0d rd=%08h", tag, LATS[idx], stalls, rd_o[idx]);
    endtask

    task automatic rst_pulse();
        set_m(0, 0, 3'b010, 32'h0, 32'h0, 0, NOP);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    typedef struct {
        bit          re;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        bit          mis;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        logic [31:0] exp_rd, instr, tgt;
        bit mis, re, we, rw;
        logic [2:0] f3;
        logic [31:0] addr, wd;

        tbl[0]  = '{0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 0, 32'h0};
        tbl[1]  = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1, 3'b000, 32'h13,  32'h00000080, 0, 32'h0};
        tbl[3]  = '{1, 0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFF80};
        tbl[4]  = '{1, 0, 3'b100, 32'h13,  32'h0,        0, 32'h00000080};
        tbl[5]  = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF};
        tbl[6]  = '{1, 0, 3'b001, 32'h11,  32'h0,        1, 32'h0};
        tbl[7]  = '{0, 1, 3'b010, 32'h12,  32'h01234567, 1, 32'h0};
        tbl[8]  = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h80ADBEEF};
        tbl[9]  = '{1, 0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFF80AD};
        tbl[10] = '{1, 0, 3'b101, 32'h10,  32'h0,        0, 32'h0000BEEF};
        tbl[11] = '{0, 1, 3'b001, 32'h12,  32'hAAAA1234, 0, 32'h0};
        tbl[12] = '{1, 0, 3'b010, 32'h10,  32'h0,        0, 32'h1234BEEF};
        tbl[13] = '{1, 0, 3'b000, 32'h11,  32'h0,        0, 32'hFFFFFFBE};
        tbl[14] = '{1, 0, 3'b011, 32'h10,  32'h0,        0, 32'h1234BEEF};
        tbl[15] = '{1, 0, 3'b010, 32'h110, 32'h0,        0, 32'h1234BEEF};
        tbl[16] = '{1, 0, 3'b101, 32'h13,  32'h0,        1, 32'h0};
        tbl[17] = '{1, 0, 3'b100, 32'h12,  32'h0,        0, 32'h00000034};
        tbl[18] = '{0, 1, 3'b000, 32'h10,  32'h0000005A, 0, 32'h0};
        tbl[19] = '{1, 0, 3'b001, 32'h10,  32'h0,        0, 32'hFFFFBE5A};

        BranchM = 1'b0; ZeroM = 1'b0; PCTargetM = '0;
        set_m(0, 0, 3'b010, 32'h0, 32'h0, 0, NOP);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset RegWriteW", 32'(rw_o[i]), 32'd0);
            chk("reset memtoRegW", 32'(m2r_o[i]), 32'd0);
            chk("reset ALUOutW", alu_o[i], 32'd0);
            chk("reset ReadDataW", rd_o[i], 32'd0);
            chk("reset InstrW", ins_o[i], 32'd0);
            chk("reset StallM", 32'(stall_o[i]), 32'd0);
        end
        rst = 1'b0;

        // Branch resolution is purely combinational.
        tgt = $urandom;
        BranchM = 1'b1; ZeroM = 1'b1; PCTargetM = tgt; #2;
        chk("branch taken PCSrcM", 32'(pcsrc_o[0]), 32'd1);
        chk("branch PCTargetOut", pct_o[0], tgt);
        ZeroM = 1'b0; #2;
        chk("branch not-zero PCSrcM", 32'(pcsrc_o[0]), 32'd0);
        BranchM = 1'b0; ZeroM = 1'b1; #2;
        chk("no-branch PCSrcM", 32'(pcsrc_o[0]), 32'd0);
        BranchM = 1'b0; ZeroM = 1'b0;
        @(posedge clk); #1;

        // Directed vectors on the zero-latency instance.
        for (int v = 0; v < 20; v++) begin
            instr = $urandom;
            set_m(tbl[v].re, tbl[v].we, tbl[v].f3, tbl[v].addr, tbl[v].wd, tbl[v].re, instr);
            #3;
            chk($sformatf("vec%0d MisalignM", v), 32'(misal_o[0]), 32'(tbl[v].mis));
            chk($sformatf("vec%0d StallM", v), 32'(stall_o[0]), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d RegWriteW", v), 32'(rw_o[0]), 32'(tbl[v].re & ~tbl[v].mis));
            chk($sformatf("vec%0d InstrW", v), ins_o[0], instr);
            if (tbl[v].re) chk($sformatf("vec%0d ReadDataW", v), rd_o[0], tbl[v].rd);
            $display("txn vec%0d: re=%0d we=%0d f3=%03b addr=%08h rd=%08h mis=%0d",
                     v, tbl[v].re, tbl[v].we, tbl[v].f3, tbl[v].addr, rd_o[0], tbl[v].mis);
        end

        // Randomized traffic: fill memory first so the model knows every byte.
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            set_m(0, 1, 3'b010, 32'(w * 4), wd, 0, NOP);
            model_store(3'b010, 32'(w * 4), wd);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 300; i++) begin
            int op = $urandom_range(0, 2);
            re = (op == 1); we = (op == 2);
            f3 = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 4 * NBYTES - 1);
            wd = $urandom; rw = 1'($urandom_range(0, 1)); instr = $urandom;
            mis = (re | we) && mis_of(f3, addr);
            exp_rd = (re && !mis) ? model_load(f3, addr) : 32'h0;
            set_m(re, we, f3, addr, wd, rw, instr);
            #3;
            chk($sformatf("rnd%0d MisalignM", i), 32'(misal_o[0]), 32'(mis));
            chk($sformatf("rnd%0d StallM", i), 32'(stall_o[0]), 32'd0);
            if (we && !mis) model_store(f3, addr, wd);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d RegWriteW", i), 32'(rw_o[0]), 32'(rw & ~mis));
            chk($sformatf("rnd%0d InstrW", i), ins_o[0], instr);
            chk($sformatf("rnd%0d ALUOutW", i), alu_o[0], addr);
            if (re) chk($sformatf("rnd%0d ReadDataW", i), rd_o[0], exp_rd);
            $display("txn rnd%0d: re=%0d we=%0d f3=%03b addr=%08h rd=%08h mis=%0d",
                     i, re, we, f3, addr, rd_o[0], mis);
        end

        // MEM_LAT=3: store then back-to-back load, three stall cycles each.
        rst_pulse();
        set_m(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 32'h00202023);
        run_until_done(2, "lat3 SW", stalls);
        chk("lat3 SW stall count", 32'(stalls), 32'd3);
        set_m(1, 0, 3'b010, 32'h20, 32'h0, 1, 32'h00002083);
        run_until_done(2, "lat3 LW", stalls);
        chk("lat3 LW stall count", 32'(stalls), 32'd3);
        chk("lat3 LW ReadDataW", rd_o[2], 32'hCAFEF00D);
        chk("lat3 LW RegWriteW", 32'(rw_o[2]), 32'd1);
        chk("lat3 LW InstrW", ins_o[2], 32'h00002083);

        // MEM_LAT=2: reset during the wait of a store discards it.
        rst_pulse();
        set_m(0, 1, 3'b010, 32'h30, 32'h11111111, 0, 32'h00202823);
        run_until_done(1, "lat2 SW old", stalls);
        chk("lat2 SW stall count", 32'(stalls), 32'd2);
        set_m(0, 1, 3'b010, 32'h30, 32'h22222222, 0, 32'h00202823);
        #3; @(posedge clk); #1;
        chk("lat2 StallM in wait", 32'(stall_o[1]), 32'd1);
        #1; rst = 1'b1; #1;
        chk("lat2 StallM async drop", 32'(stall_o[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_m(1, 0, 3'b010, 32'h30, 32'h0, 1, 32'h03002083);
        run_until_done(1, "lat2 LW after reset", stalls);
        chk("lat2 LW stall count", 32'(stalls), 32'd2);
        chk("lat2 LW ReadDataW", rd_o[1], 32'h11111111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
